// File: rtl/seg7_display_driver.sv
// seg7_display_driver
// Converts a 10-bit binary value to four BCD digits with a sequential
// double-dabble engine. The result drives a time-multiplexed, common-anode,
// 4-digit 7-segment display. Optionally blanks leading zeros.
module seg7_display_driver #(
    parameter int REFRESH_CNT = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  din,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [9:0]  last_val, last_val_next;
    logic [9:0]  latched, latched_next;
    logic [9:0]  shift_reg, shift_next;
    logic [15:0] scratch, scratch_next;
    logic [3:0]  count, count_next;
    logic [15:0] bcd_next;
    logic        busy_next;
    logic [15:0] scratch_adj;

    logic [15:0] refresh_cnt;
    logic [1:0]  digit_idx;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;

    // Decimal point is never used on this board.
    assign dp = 1'b1;

    // Maps one BCD nibble to active-low segments; non-decimal codes are blank.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            scratch_adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ?
                                    scratch[4*k +: 4] + 4'd3 : scratch[4*k +: 4];
        end
    end

    // Conversion state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_val  <= '0;
            latched   <= '0;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            last_val  <= last_val_next;
            latched   <= latched_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            count     <= count_next;
            bcd       <= bcd_next;
            busy      <= busy_next;
        end
    end

    // Conversion FSM: capture a changed input, run ten adjust-and-shift steps, publish.
    always_comb begin
        state_next    = state;
        last_val_next = last_val;
        latched_next  = latched;
        shift_next    = shift_reg;
        scratch_next  = scratch;
        count_next    = count;
        bcd_next      = bcd;
        busy_next     = busy;
        case (state)
            IDLE: begin
                if (din != last_val) begin
                    latched_next = din;
                    shift_next   = din;
                    scratch_next = '0;
                    count_next   = '0;
                    busy_next    = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_next, shift_next} = {scratch_adj[14:0], shift_reg, 1'b0};
                if (count == 4'd9) begin
                    state_next = DONE;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            DONE: begin
                bcd_next      = scratch;
                last_val_next = latched;
                busy_next     = 1'b0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Refresh timer: each digit stays enabled for REFRESH_CNT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == 16'(REFRESH_CNT - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
        end
    end

    // Selects the active digit and applies leading-zero blanking (units never blanks).
    always_comb begin
        an_next  = ~(4'b0001 << digit_idx);
        seg_next = decode(bcd[4*digit_idx +: 4]);
        if (BLANK_LZ) begin
            case (digit_idx)
                2'd1:    if (bcd[15:4]  == 12'd0) seg_next = 7'h7F;
                2'd2:    if (bcd[15:8]  == 8'd0)  seg_next = 7'h7F;
                2'd3:    if (bcd[15:12] == 4'd0)  seg_next = 7'h7F;
                default: ;
            endcase
        end
    end

    // Registered display drive so the pins stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
